// File: rtl/scaler_chain_pkg.sv
// Shared timer constants and helpers for the scaler divider chain.
package scaler_chain_pkg;

  localparam int SCALER_NSTAGES_DEFAULT = 16;
  localparam int SCALER_STALL_DEFAULT   = 64;

  // Wide enough to hold STALL_LIMIT itself, since the counter saturates there.
  function automatic int stall_cnt_width(input int stall_limit);
    return $clog2(stall_limit + 1);
  endfunction

endpackage

// File: rtl/scaler_stall_monitor.sv
// Raises SCAFAL when FS01 has shown no edge for STALL_LIMIT clocks; any edge clears it.
module scaler_stall_monitor
  import scaler_chain_pkg::*;
#(
  parameter int STALL_LIMIT = SCALER_STALL_DEFAULT
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic fs01_edge,
  output logic SCAFAL
);

  localparam int             CNT_W = stall_cnt_width(STALL_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             scafal_q, scafal_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    scafal_d    = scafal_q;
    if (fs01_edge) begin
      stall_cnt_d = '0;
      scafal_d    = 1'b0;
    end else begin
      if (stall_cnt_q != LIMIT) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (stall_cnt_d == LIMIT) begin
        scafal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      stall_cnt_q <= '0;
      scafal_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      scafal_q    <= scafal_d;
    end
  end

  assign SCAFAL = scafal_q;

endmodule

// File: rtl/scaler_chain.sv
// Binary divider chain FS02..FS(NSTAGES+1) clocked by FS01 falling edges,
// with per-stage rise/fall pulses and an FS01 stall alarm.
module scaler_chain
  import scaler_chain_pkg::*;
#(
  parameter int NSTAGES     = SCALER_NSTAGES_DEFAULT,
  parameter int STALL_LIMIT = SCALER_STALL_DEFAULT
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               FS01,
  input  logic               SCLR,
  output logic [NSTAGES-1:0] FS,
  output logic [NSTAGES-1:0] FA,
  output logic [NSTAGES-1:0] FB,
  output logic               SCAFAL
);

  logic               fs01_q;
  logic               fs01_fall;
  logic               fs01_edge;
  logic [NSTAGES-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NSTAGES-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [NSTAGES-1:0] stage_rise, stage_fall;

  assign fs01_fall = fs01_q & ~FS01;
  assign fs01_edge = fs01_q ^ FS01;
  assign cnt_inc   = cnt_q + NSTAGES'(1);

  // A stage rises/falls on increment exactly where its bit flips 0->1 / 1->0.
  generate
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
      assign stage_rise[gi] = ~cnt_q[gi] &  cnt_inc[gi];
      assign stage_fall[gi] =  cnt_q[gi] & ~cnt_inc[gi];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    fa_d  = '0;
    fb_d  = '0;
    // Clear wins over a coincident fall; that fall is deliberately dropped.
    if (SCLR) begin
      cnt_d = '0;
    end else if (fs01_fall) begin
      cnt_d = cnt_inc;
      fa_d  = stage_rise;
      fb_d  = stage_fall;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      fs01_q <= 1'b0;
      cnt_q  <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
    end else begin
      fs01_q <= FS01;
      cnt_q  <= cnt_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
    end
  end

  scaler_stall_monitor #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .fs01_edge(fs01_edge),
    .SCAFAL   (SCAFAL)
  );

  assign FS = cnt_q;
  assign FA = fa_q;
  assign FB = fb_q;

endmodule

// File: tb/tb_scaler_chain.sv
// Randomized and directed bench for scaler_chain against a behavioural fall-count model.
module tb_scaler_chain;

  localparam int LIM = 8;

  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;
  logic FS01    = 1'b0;
  logic SCLR    = 1'b0;

  logic [15:0] fs16, fa16, fb16;
  logic        scafal16;
  logic [3:0]  fs4, fa4, fb4;
  logic        scafal4;

  scaler_chain #(.NSTAGES(16), .STALL_LIMIT(LIM)) u_dut16 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .FS01(FS01), .SCLR(SCLR),
    .FS(fs16), .FA(fa16), .FB(fb16), .SCAFAL(scafal16)
  );

  scaler_chain #(.NSTAGES(4), .STALL_LIMIT(LIM)) u_dut4 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .FS01(FS01), .SCLR(SCLR),
    .FS(fs4), .FA(fa4), .FB(fb4), .SCAFAL(scafal4)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of counted falls, cycles since last FS01 edge.
  logic        m_prev  = 1'b0;
  int          m_count = 0;
  int          m_since = 0;
  logic        m_alarm = 1'b0;
  logic [15:0] m_fa    = '0;
  logic [15:0] m_fb    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic fs, input logic clr, input logic rst);
    logic [15:0] o, n;
    if (rst) begin
      m_prev = 1'b0; m_count = 0; m_since = 0; m_alarm = 1'b0;
      m_fa = '0; m_fb = '0;
      return;
    end
    m_fa = '0;
    m_fb = '0;
    if (clr) begin
      m_count = 0;
    end else if (m_prev && !fs) begin
      o = 16'(m_count);
      m_count = (m_count + 1) % 65536;
      n = 16'(m_count);
      for (int k = 0; k < 16; k++) begin
        m_fa[k] = !o[k] && n[k];
        m_fb[k] = o[k] && !n[k];
      end
      $display("[TB] fall counted: cnt=%0d fa=%04h fb=%04h", m_count, m_fa, m_fb);
    end
    if (m_prev != fs) begin
      m_since = 0;
      m_alarm = 1'b0;
    end else begin
      if (m_since < LIM) m_since++;
      if (m_since >= LIM) m_alarm = 1'b1;
    end
    m_prev = fs;
  endtask

  task automatic tick(input logic fs, input logic clr, input logic rst);
    logic [15:0] mc;
    FS01 = fs; SCLR = clr; SIM_RST = rst;
    @(posedge SIM_CLK);
    model_edge(fs, clr, rst);
    #1;
    mc = 16'(m_count);
    check("fs16",     32'(fs16),     32'(mc));
    check("fa16",     32'(fa16),     32'(m_fa));
    check("fb16",     32'(fb16),     32'(m_fb));
    check("scafal16", 32'(scafal16), 32'(m_alarm));
    check("fs4",      32'(fs4),      32'(mc[3:0]));
    check("fa4",      32'(fa4),      32'(m_fa[3:0]));
    check("fb4",      32'(fb4),      32'(m_fb[3:0]));
    check("scafal4",  32'(scafal4),  32'(m_alarm));
  endtask

  task automatic fall_once();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] saved;
    int          left;
    logic        lvl;

    // Reset state
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_fs",  32'(fs16), 32'd0);
    check("rst_fa",  32'(fa16), 32'd0);
    check("rst_scafal", 32'(scafal16), 32'd0);

    // Four 4-high / 4-low periods
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check("period_fs", 32'(fs16), 32'(p + 1));
      if (p == 1) check("fa1_fb0", 32'({fa16[1], fb16[0]}), 32'd3);
      tick(1'b0, 1'b0, 1'b0);
      check("pulse_width", 32'(fa16 | fb16), 32'd0);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
    end

    // Wrap of the 4-stage chain
    while ((m_count % 16) != 15) fall_once();
    fall_once();
    check("wrap_fs4", 32'(fs4), 32'd0);
    check("wrap_fb4", 32'(fb4), 32'hF);
    check("wrap_fa4", 32'(fa4), 32'd0);

    // Stall alarm timing, then recovery
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0);
    check("stall_early", 32'(scafal16), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    check("stall_hit", 32'(scafal16), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    saved = fs16;
    tick(1'b1, 1'b0, 1'b0);
    check("stall_clear", 32'(scafal16), 32'd0);
    check("stall_cnt_hold", 32'(fs16), 32'(saved));
    tick(1'b0, 1'b0, 1'b0);
    check("stall_next_fall", 32'(fs16), 32'(saved + 16'd1));

    // SCLR coincident with a fall at cnt=5
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) fall_once();
    check("pre_clr", 32'(fs16), 32'd5);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("clr_fs", 32'(fs16), 32'd0);
    check("clr_pulses", 32'(fa16 | fb16), 32'd0);
    fall_once();
    check("clr_next_fs", 32'(fs16), 32'd1);
    check("clr_next_fa0", 32'(fa16[0]), 32'd1);

    // Reset mid-count and mid-alarm
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) fall_once();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(fs16), 32'd9);
    check("pre_rst_alarm", 32'(scafal16), 32'd1);
    tick(1'b0, 1'b1, 1'b1);
    check("rst_all", 32'({fs16, fa16, fb16, scafal16}), 32'd0);
    fall_once();
    check("rst_restart", 32'(fs16), 32'd1);

    // Fastest legal toggling: every cycle
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick((i % 2) == 0, 1'b0, 1'b0);
    check("fast_toggle", 32'(fs16), 32'd10);

    // Random levels, clears and resets
    lvl = 1'b0;
    left = 0;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = $urandom_range(1, 12);
      end
      left--;
      tick(lvl, $urandom_range(0, 31) == 0, $urandom_range(0, 79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
